// File: rtl/jh_mem_pkg.sv
// jh_mem_pkg: shared widths, arbiter state encoding and requester ids for the data-RAM arbiter
package jh_mem_pkg;
    localparam int AW_DEF = 10;
    localparam int DW_DEF = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_HOST = 1'b1;
endpackage

// File: rtl/jh_arb_pick.sv
// jh_arb_pick: combinational winner selection between the CPU and host requesters
module jh_arb_pick
    import jh_mem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    input  logic rr,
    input  logic wait_sat,
    output logic winner,
    output logic valid
);
    // A tie goes to whoever was not granted last, or to the host once it has starved long enough
    always_comb begin
        valid = req0 | req1;
        winner = (req0 && req1) ? (rr ? ~pointer : wait_sat) : (req1 ? REQ_HOST : REQ_CPU);
    end
endmodule

// File: rtl/jh_dmem_arbiter.sv
// jh_dmem_arbiter: shares the single-port data RAM between the CPU data port and the host loader
module jh_dmem_arbiter
    import jh_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter bit RR = 1'b1,
    parameter int MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q,
    output logic          busy
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t        state;
    logic          pointer, cur_id, cur_we, winner, valid, wait_sat;
    logic [WW-1:0] wait1;

    assign wait_sat = wait1 == WW'(MAX_WAIT);
    assign busy = state != IDLE;

    jh_arb_pick u_pick (
        .req0(req0),
        .req1(req1),
        .pointer(pointer),
        .rr(RR),
        .wait_sat(wait_sat),
        .winner(winner),
        .valid(valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            mem_address <= '0;
            mem_data <= '0;
            mem_we <= 1'b0;
            pointer <= REQ_HOST;
            wait1 <= '0;
            cur_id <= REQ_CPU;
            cur_we <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (state == ISSUE) begin
                mem_we <= 1'b0;
                state <= CAPTURE;
            end else begin
                // CAPTURE retires the access in flight and arbitrates the next one on the same edge
                if (state == CAPTURE) begin
                    done0 <= cur_id == REQ_CPU;
                    done1 <= cur_id == REQ_HOST;
                    if (!cur_we && cur_id == REQ_CPU) rdata0 <= mem_q;
                    if (!cur_we && cur_id == REQ_HOST) rdata1 <= mem_q;
                end
                state <= valid ? ISSUE : IDLE;
                if (!RR) wait1 <= (req1 && winner == REQ_CPU) ? (wait_sat ? wait1 : wait1 + WW'(1)) : '0;
                if (valid) begin
                    gnt0 <= winner == REQ_CPU;
                    gnt1 <= winner == REQ_HOST;
                    pointer <= winner;
                    cur_id <= winner;
                    cur_we <= winner ? we1 : we0;
                    mem_we <= winner ? we1 : we0;
                    mem_address <= winner ? addr1 : addr0;
                    mem_data <= winner ? wdata1 : wdata0;
                end
            end
        end
    end
endmodule

// File: tb/tb_jh_dmem_arbiter.sv
// tb_jh_dmem_arbiter: scoreboard bench driving a round-robin lane and a fixed-priority lane side by side
module tb_jh_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MW = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int phase = 0;
    logic [1:0] rst_ready = 2'b00;
    logic [1:0] lane_fin = 2'b00;

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 5) ? 16'h1234 : ((16'(a) * 16'h9e37) ^ 16'h5a5a);
    endfunction

    task automatic chk(input int ln, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got %0h expected %0h at %0t", ln, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam bit LRR = (g == 0);
        typedef struct {
            logic id;
            logic we;
            logic [DW-1:0] rd;
            int due;
        } exp_t;

        logic [1:0] req = 2'b00;
        logic [1:0] we = 2'b00;
        logic [1:0] gnt, done;
        logic [AW-1:0] addr [2];
        logic [DW-1:0] wdata [2];
        logic [DW-1:0] rdata [2];
        logic [AW-1:0] mem_address, raddr;
        logic [DW-1:0] mem_data, mem_q;
        logic mem_we, busy;
        logic [DW-1:0] ram [1 << AW];
        logic ram_ready = 1'b0;

        exp_t q[$];
        logic [DW-1:0] shadow [int];
        logic [DW-1:0] exp_rd [2];
        int gorder[$];
        bit rec = 1'b0;
        logic [1:0] p_req, p_we;
        logic [AW-1:0] p_addr [2];
        logic [DW-1:0] p_wdata [2];
        bit prev_g, just_rst;
        logic last;
        int wait1, cyc;

        jh_dmem_arbiter #(.AW(AW), .DW(DW), .RR(LRR), .MAX_WAIT(MW)) dut (
            .clock(clock),
            .reset_n(reset_n),
            .req0(req[0]),
            .req1(req[1]),
            .we0(we[0]),
            .we1(we[1]),
            .addr0(addr[0]),
            .addr1(addr[1]),
            .wdata0(wdata[0]),
            .wdata1(wdata[1]),
            .gnt0(gnt[0]),
            .gnt1(gnt[1]),
            .done0(done[0]),
            .done1(done[1]),
            .rdata0(rdata[0]),
            .rdata1(rdata[1]),
            .mem_address(mem_address),
            .mem_data(mem_data),
            .mem_we(mem_we),
            .mem_q(mem_q),
            .busy(busy)
        );

        // RAM macro: registered address/data/we, unregistered q
        always @(posedge clock) begin
            if (!ram_ready) begin
                for (int i = 0; i < (1 << AW); i++) ram[i] <= init_val(i);
                ram_ready <= 1'b1;
            end else if (mem_we) begin
                ram[mem_address] <= mem_data;
            end
            raddr <= mem_address;
        end
        assign mem_q = ram[raddr];

        always @(negedge reset_n) begin
            #1;
            chk(g, "async_reset_we_gnt", {gnt, mem_we}, 0);
        end

        // Reference model: one access per arbitration opportunity, done two edges after grant
        always @(negedge clock) begin : mon
            logic arb, w, eg;
            logic [1:0] exp_d;
            logic [DW-1:0] rd;
            exp_t e;
            if (!reset_n) begin
                chk(g, "rst_ctrl", {gnt, done, mem_we, busy}, 0);
                chk(g, "rst_rdata", {rdata[1], rdata[0]}, 0);
                chk(g, "rst_mem", {mem_address, mem_data}, 0);
                q.delete();
                prev_g = 1'b0;
                just_rst = 1'b1;
                last = 1'b1;
                wait1 = 0;
                exp_rd[0] = '0;
                exp_rd[1] = '0;
            end else begin
                cyc++;
                arb = !prev_g && !just_rst;
                eg = arb && (p_req != 2'b00);
                w = (p_req == 2'b11) ? (LRR ? !last : (wait1 == MW)) : p_req[1];
                exp_d = 2'b00;
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    exp_d[e.id] = 1'b1;
                    if (!e.we) exp_rd[e.id] = e.rd;
                end
                chk(g, "done", done, exp_d);
                chk(g, "rdata0", rdata[0], exp_rd[0]);
                chk(g, "rdata1", rdata[1], exp_rd[1]);
                chk(g, "gnt", gnt, eg ? (w ? 2'b10 : 2'b01) : 2'b00);
                chk(g, "mem_we", mem_we, eg && p_we[w]);
                chk(g, "busy", busy, eg || prev_g);
                if (rec && gnt != 2'b00) gorder.push_back(int'(gnt[1]));
                if (eg) begin
                    chk(g, "mem_address", mem_address, p_addr[w]);
                    rd = shadow.exists(int'(p_addr[w])) ? shadow[int'(p_addr[w])] : init_val(int'(p_addr[w]));
                    if (p_we[w]) begin
                        chk(g, "mem_data", mem_data, p_wdata[w]);
                        shadow[int'(p_addr[w])] = p_wdata[w];
                    end
                    e.id = w;
                    e.we = p_we[w];
                    e.rd = rd;
                    e.due = cyc + 2;
                    q.push_back(e);
                    last = w;
                end
                if (arb && !LRR) wait1 = (eg && p_req[1] && !w) ? ((wait1 < MW) ? wait1 + 1 : MW) : 0;
                prev_g = eg;
                just_rst = 1'b0;
            end
            p_req = req;
            p_we = we;
            p_addr = addr;
            p_wdata = wdata;
        end

        task automatic idle(input int n);
            repeat (n) begin
                @(posedge clock);
                #1;
            end
        endtask

        task automatic access(input int id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
            int n = 0;
            req[id] = 1'b1;
            we[id] = w;
            addr[id] = a;
            wdata[id] = d;
            do begin
                @(posedge clock);
                #1;
                n++;
            end while (!gnt[id] && n < 40);
            chk(g, $sformatf("gnt%0d_wait", id), gnt[id], 1'b1);
            req[id] = 1'b0;
        endtask

        initial begin
            addr[0] = '0;
            addr[1] = '0;
            wdata[0] = '0;
            wdata[1] = '0;
            wait (phase == 1);
            access(1, 1'b0, 10'h005, '0);
            idle(4);
            access(0, 1'b1, 10'h00a, 16'hbeef);
            access(0, 1'b0, 10'h00a, '0);
            idle(4);
            access(0, 1'b1, 10'h020, 16'hdead);
            chk(g, "we_before_reset", mem_we, 1'b1);
            rst_ready[g] = 1'b1;
            wait (phase == 2);
            rec = 1'b1;
            fork
                for (int i = 0; i < 10; i++) access(0, 1'b0, 10'(i), '0);
                for (int i = 0; i < 10; i++) access(1, 1'b0, 10'(i + 16), '0);
            join
            rec = 1'b0;
            chk(g, "order_len", gorder.size() >= 10, 1);
            for (int i = 0; i < 10 && i < gorder.size(); i++)
                chk(g, "grant_order", gorder[i], LRR ? (i % 2) : int'(i % 5 == 4));
            fork
                for (int i = 0; i < 30; i++) begin
                    idle($urandom_range(0, 3));
                    access(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom));
                end
                for (int i = 0; i < 30; i++) begin
                    idle($urandom_range(0, 3));
                    access(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom));
                end
            join
            idle(12);
            access(0, 1'b0, 10'h003, '0);
            idle(4);
            fork
                access(0, 1'b0, 10'h00a, '0);
                access(1, 1'b0, 10'h005, '0);
            join
            idle(6);
            lane_fin[g] = 1'b1;
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        phase = 1;
        for (int i = 0; i < 20000 && rst_ready != 2'b11; i++) #1;
        chk(0, "reset_setup", rst_ready, 2'b11);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        phase = 2;
        for (int i = 0; i < 20000 && lane_fin != 2'b11; i++) @(posedge clock);
        chk(0, "lanes_finished", lane_fin, 2'b11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jh_dmem_arbiter.md
# jh_dmem_arbiter

Two-port arbiter sharing the single-port 1024×16 data RAM between the CPU data port (requester 0) and a host/debug loader port (requester 1). Sits between the CPU core, the loader, and the RAM macro (registered address/data/we, unregistered q). Sequences each access as issue → capture, returns read data per requester, and enforces fairness by round-robin or by fixed priority with a starvation bound.

## Interface
Parameters:
- AW, 10, RAM address width
- DW, 16, data width
- RR, 1, 1 = round-robin; 0 = fixed priority to requester 0 with starvation bound
- MAX_WAIT, 4, lost arbitrations tolerated by requester 1 in fixed mode (≥1)

Ports:
- Reset is reset_n, asynchronous, active-low; clock is clock.
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request; held until gntN seen
- we0 / we1  in  1  1 = write, 0 = read; stable while reqN high
- addr0 / addr1  in  AW  word address; stable while reqN high
- wdata0 / wdata1  in  DW  write data; stable while reqN high
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted
- done0 / done1  out  1  one-cycle pulse: access complete
- rdata0 / rdata1  out  DW  read data, valid with doneN for reads, held until next read by that requester
- mem_address  out  AW  to RAM address
- mem_data  out  DW  to RAM data
- mem_we  out  1  to RAM write enable
- mem_q  in  DW  RAM output
- busy  out  1  high in ISSUE and CAPTURE

## Operation
- States: IDLE, ISSUE, CAPTURE. Encoding is a shared constant.
- Arbitration edge: an edge in IDLE, or in CAPTURE. If any reqN is high, pick a winner, register mem_address/mem_data/mem_we from the winner, pulse gntN, latch winner id and op, and go to ISSUE. Otherwise go to or stay in IDLE.
- Only one requester high: that requester wins.
- Both high, RR=1: winner is the requester not granted last. The last-granted pointer resets to 1, so requester 0 wins the first tie.
- Both high, RR=0: requester 0 wins, unless wait1 == MAX_WAIT, in which case requester 1 wins.
- wait1 counter (RR=0 only): saturates at MAX_WAIT. +1 on each arbitration edge where req1 is high and requester 0 wins. Cleared when requester 1 wins or when req1 is low at an arbitration edge.
- ISSUE → CAPTURE unconditionally. mem_we is cleared at this edge, so the write enable is high exactly one cycle.
- CAPTURE edge: pulse doneN for the latched winner. For reads, also register mem_q into rdataN. In the same edge, arbitrate again as above.
- A requester must drop reqN, or present a new request, on the cycle after gntN. A req still high at the CAPTURE edge counts as a new request.
- mem_address/mem_data hold their last values outside ISSUE. mem_we is 0 outside ISSUE.

## Timing
- Reset values: state IDLE, gnt0/1=0, done0/1=0, rdata0/1=0, mem_address=0, mem_data=0, mem_we=0, busy=0, wait1=0, pointer=1. Reset mid-access aborts the access with no done. mem_we drops asynchronously.
- Edge E0 (arbitration): gntN is high in cycle E0–E1 and the RAM inputs are driven.
- Edge E1: the RAM latches; mem_q is valid in cycle E1–E2.
- Edge E2: doneN and rdataN are updated. Latency from req sampled to done is 2 edges.
- Throughput: one access per 2 cycles under back-to-back load. gnt for the next access coincides with done of the previous one.
- Read-after-write to the same address by either requester returns the new data.

## Structure
- Package jh_mem_pkg holds AW/DW defaults, the state encoding (IDLE=0, ISSUE=1, CAPTURE=2), and the requester id constants.
- Sub-module jh_arb_pick is combinational. Inputs: req0, req1, pointer, RR, wait1 saturation flag. Output: winner id and a valid flag. Everything else stays in the top.

## Test plan
- Single read: preload RAM[0x005]=0x1234; req1 read of 0x005 → gnt1 the cycle after E0, done1 two edges after request, rdata1=0x1234, mem_we never high.
- Write then read: req0 writes 0x00A=0xBEEF, then reads 0x00A → mem_we high exactly 1 cycle, rdata0=0xBEEF.
- RR tie: both request continuously from reset, RR=1 → grants alternate 0,1,0,1. Each done follows 2 edges after gnt. busy stays high.
- Fixed priority with starvation, RR=0, MAX_WAIT=4: both request continuously → grant order 0,0,0,0,1,0,0,0,0,1, and wait1 returns to 0 after each grant 1.
- Reset mid-access: reset_n low during ISSUE of a write → mem_we=0 immediately, no done pulse, all outputs at reset values. The first access after release completes normally.
- Idle gap: a single req0 after 10 idle cycles → state returns to IDLE, busy=0 between accesses, the pointer is unchanged by idle cycles.
